cisr_decoder: RTL and testbench

Row-ID decoder for a 4-lane CISR (Compressed Interleaved Sparse Row) sparse matrix-vector datapath. Each lane streams one nonzero per clock. The block tracks how many nonzeros remain in each lane's current row and hands out new global row IDs in ascending order as lanes finish rows. It sits between the row-length stream and the per-lane multiply/accumulate units, tagging each lane's current element with its row ID.

---
 rtl/cisr_decoder.sv | 65 ++++++
 tb/tb_cisr_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cisr_decoder.sv
// Row-ID decoder for a 4-lane CISR sparse matrix-vector datapath.
// Tracks per-lane remaining row length and hands out ascending global row IDs.
module cisr_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rowLength1,
  input  logic [4:0] rowLength2,
  input  logic [4:0] rowLength3,
  input  logic [4:0] rowLength4,
  output logic [4:0] rowID1,
  output logic [4:0] rowID2,
  output logic [4:0] rowID3,
  output logic [4:0] rowID4
);

  logic [4:0] r_rowID [4];
  logic [4:0] r_rem [4];
  logic [4:0] r_nextRow;

  logic [4:0] w_len [4];
  logic [3:0] w_need;
  logic [4:0] w_offset [4];
  logic [4:0] w_needCount;

  assign w_len[0] = rowLength1;
  assign w_len[1] = rowLength2;
  assign w_len[2] = rowLength3;
  assign w_len[3] = rowLength4;

  // Running count of needing lanes gives each lane its offset; lower lanes win lower IDs.
  always_comb begin
    w_needCount = '0;
    for (int i = 0; i < 4; i++) begin
      w_need[i]   = (r_rem[i] <= 5'd1);
      w_offset[i] = w_needCount;
      w_needCount = w_needCount + {4'd0, w_need[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_rowID[i] <= '0;
        r_rem[i]   <= '0;
      end
      r_nextRow <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_need[i]) begin
          r_rowID[i] <= r_nextRow + w_offset[i];
          r_rem[i]   <= w_len[i];
        end else begin
          r_rem[i]   <= r_rem[i] - 5'd1;
        end
      end
      r_nextRow <= r_nextRow + w_needCount;
    end
  end

  assign rowID1 = r_rowID[0];
  assign rowID2 = r_rowID[1];
  assign rowID3 = r_rowID[2];
  assign rowID4 = r_rowID[3];

endmodule

// File: tb/tb_cisr_decoder.sv
// Self-checking bench for cisr_decoder: directed scenarios plus randomized
// row lengths compared against a lane-level row-assignment model.
module tb_cisr_decoder;

  logic       clk;
  logic       reset;
  logic [4:0] rowLength [4];
  logic [4:0] rowID1, rowID2, rowID3, rowID4;

  int checks = 0;
  int errors = 0;

  // Reference model: elements left in each lane's row, the ID it holds, next free ID.
  int mLeft [4];
  int mId   [4];
  int mNext;

  cisr_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .rowLength1 (rowLength[0]),
    .rowLength2 (rowLength[1]),
    .rowLength3 (rowLength[2]),
    .rowLength4 (rowLength[3]),
    .rowID1     (rowID1),
    .rowID2     (rowID2),
    .rowID3     (rowID3),
    .rowID4     (rowID4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int laneOut(input int lane);
    case (lane)
      0: return int'(rowID1);
      1: return int'(rowID2);
      2: return int'(rowID3);
      default: return int'(rowID4);
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mLeft[i] = 0;
      mId[i]   = 0;
    end
    mNext = 0;
  endtask

  // A lane whose current element is its last (or that is idle) takes the next free row.
  task automatic modelEdge();
    int taken;
    taken = 0;
    for (int i = 0; i < 4; i++) begin
      if (mLeft[i] <= 1) begin
        mId[i]   = (mNext + taken) % 32;
        mLeft[i] = int'(rowLength[i]);
        taken++;
      end else begin
        mLeft[i] = mLeft[i] - 1;
      end
    end
    mNext = (mNext + taken) % 32;
  endtask

  task automatic checkModel(input string tag);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s lane%0d", tag, i + 1), laneOut(i), mId[i]);
  endtask

  task automatic checkLanes(input string tag, input int e1, input int e2, input int e3, input int e4);
    checkOutput({tag, " lane1"}, int'(rowID1), e1);
    checkOutput({tag, " lane2"}, int'(rowID2), e2);
    checkOutput({tag, " lane3"}, int'(rowID3), e3);
    checkOutput({tag, " lane4"}, int'(rowID4), e4);
  endtask

  task automatic applyStimulus(input int l1, input int l2, input int l3, input int l4);
    rowLength[0] = 5'(l1);
    rowLength[1] = 5'(l2);
    rowLength[2] = 5'(l3);
    rowLength[3] = 5'(l4);
  endtask

  // One active edge: advance the model, then compare just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkModel(tag);
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    modelReset();

    // Held in reset with the clock running
    repeat (3) begin
      @(posedge clk);
      #1;
      checkLanes("reset hold", 0, 0, 0, 0);
    end

    // Basic sequence
    applyStimulus(3, 2, 4, 1);
    @(negedge clk);
    reset = 1'b1;
    step("basic e1"); checkLanes("basic e1 const", 0, 1, 2, 3);
    step("basic e2"); checkLanes("basic e2 const", 0, 1, 2, 4);
    step("basic e3"); checkLanes("basic e3 const", 0, 5, 2, 6);
    step("basic e4"); checkLanes("basic e4 const", 7, 5, 2, 8);
    step("basic e5"); checkLanes("basic e5 const", 7, 9, 10, 11);

    // Simultaneous completion and wrap-around
    restart();
    applyStimulus(1, 1, 1, 1);
    step("all1 e1"); checkLanes("all1 e1 const", 0, 1, 2, 3);
    step("all1 e2"); checkLanes("all1 e2 const", 4, 5, 6, 7);
    guard = 0;
    while (mNext != 28 && guard < 40) begin
      step("all1 run");
      guard++;
    end
    checkOutput("reach nextRow 28", mNext, 28);
    step("wrap a"); checkLanes("wrap a const", 28, 29, 30, 31);
    step("wrap b"); checkLanes("wrap b const", 0, 1, 2, 3);

    // Mid-run wrap: offset numbering by 2 so a full group straddles 31 -> 0
    restart();
    applyStimulus(1, 1, 2, 2);
    step("skew e1");
    applyStimulus(1, 1, 1, 1);
    guard = 0;
    while (mNext != 30 && guard < 40) begin
      step("skew run");
      guard++;
    end
    checkOutput("reach nextRow 30", mNext, 30);
    step("midwrap a"); checkLanes("midwrap a const", 30, 31, 0, 1);
    step("midwrap b"); checkLanes("midwrap b const", 2, 3, 4, 5);

    // Zero-length rows on lane 2
    restart();
    applyStimulus(5, 0, 5, 5);
    step("zero e1"); checkLanes("zero e1 const", 0, 1, 2, 3);
    step("zero e2"); checkLanes("zero e2 const", 0, 4, 2, 3);
    step("zero e3"); checkLanes("zero e3 const", 0, 5, 2, 3);
    step("zero e4");
    step("zero e5"); checkLanes("zero e5 const", 0, 7, 2, 3);
    step("zero e6"); checkLanes("zero e6 const", 8, 9, 10, 11);
    repeat (6) step("zero run");

    // Asynchronous reset mid-operation
    restart();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      step("pre reset");
    end
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkLanes("async reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step("post reset"); checkLanes("post reset const", 0, 1, 2, 3);

    // Randomized lengths across the full range
    for (int c = 0; c < 400; c++) begin
      applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      if (c % 3 == 0)
        rowLength[$urandom_range(0, 3)] = 5'($urandom_range(0, 2));
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
